mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/mem_arbiter.sv | 87 ++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared CPU defines for the memory arbiter (state encoding, bus widths).
package mem_arbiter_pkg;
    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    typedef enum logic [1:0] {ARB, LOCK, DRAIN} arb_state_e;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for a single-port memory with m1 lock support.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_hold
);
    arb_state_e state_q, state_d;
    logic last_q, last_d;
    logic rd_q, rd_d;
    logic who_q, who_d;

    // last_q=1 means m1 was granted last, so m0 wins the next tie
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        m0_gnt  = (state_q == ARB) && m0_req && (!m1_req || last_q);
        m1_gnt  = (state_q == ARB) ? m1_req && (!m0_req || !last_q) : (state_q == LOCK) && m1_req;
        unique case (state_q)
            ARB: begin
                if (m0_gnt) last_d = 1'b0;
                if (m1_gnt) begin
                    last_d = 1'b1;
                    if (m1_lock) state_d = LOCK;
                end
            end
            LOCK: begin
                last_d = 1'b1;
                if (!m1_lock) state_d = (m1_gnt && !m1_we) ? DRAIN : ARB;
            end
            default: begin
                last_d  = 1'b1;
                state_d = ARB;
            end
        endcase
    end

    assign rd_d      = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
    assign who_d     = m1_gnt;
    assign mem_ce    = m0_gnt || m1_gnt;
    assign mem_we    = m0_gnt ? m0_we    : m1_gnt ? m1_we    : 1'b0;
    assign mem_addr  = m0_gnt ? m0_addr  : m1_gnt ? m1_addr  : '0;
    assign mem_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
    assign m0_rvalid = rd_q && !who_q;
    assign m1_rvalid = rd_q && who_q;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
    assign cpu_hold  = (m0_req && !m0_gnt) || (state_q != ARB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            last_q  <= 1'b1;
            rd_q    <= 1'b0;
            who_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            who_q   <= who_d;
        end
    end
endmodule
